// File: rtl/approx_adder_error_monitor.sv
// Error monitor for the approximate Brent-Kung adder: computes the exact sum and error
// distance per sample and accumulates count, saturating ED sum and max ED over a run.
module approx_adder_error_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16,
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:1]   A,
    input  logic [WIDTH:1]   B,
    input  logic [WIDTH:1]   Approx_Sum,
    input  logic             Approx_Cout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] samples_seen,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [WIDTH:0]   max_ed
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;

    logic             s1_valid;
    logic [WIDTH:1]   s1_a;
    logic [WIDTH:1]   s1_b;
    logic [WIDTH:0]   s1_approx;
    logic             s2_valid;
    logic [WIDTH:0]   s2_ed;

    logic             accept;
    logic             start_ok;
    logic [WIDTH:0]   s1_exact;
    logic [WIDTH:0]   ed_next;
    logic [ACC_W:0]   sum_next;

    always_comb begin
        accept   = in_valid && in_ready;
        start_ok = start && (state == IDLE || state == DONE);
        s1_exact = {1'b0, s1_a} + {1'b0, s1_b};
        ed_next  = (s1_exact >= s1_approx) ? (s1_exact - s1_approx) : (s1_approx - s1_exact);
        // One extra bit catches the carry that signals saturation.
        sum_next = {1'b0, sum_ed} + {{(ACC_W - WIDTH){1'b0}}, s2_ed};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_approx <= '0;
            s2_valid  <= 1'b0;
            s2_ed     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a      <= A;
                s1_b      <= B;
                s1_approx <= {Approx_Cout, Approx_Sum};
            end
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_ed <= ed_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        remaining <= num_samples;
                        if (num_samples != '0) begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                        end else begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // S1 empty means the last sample is in S2 and lands in the stats this edge.
                    if (!s1_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samples_seen <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
        end else if (start_ok) begin
            samples_seen <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
        end else if (s2_valid) begin
            samples_seen <= samples_seen + CNT_W'(1);
            if (s2_ed != '0)
                err_count <= err_count + CNT_W'(1);
            sum_ed <= sum_next[ACC_W] ? '1 : sum_next[ACC_W-1:0];
            if (s2_ed > max_ed)
                max_ed <= s2_ed;
        end
    end

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Directed bench for approx_adder_error_monitor: exact/inexact samples, empty runs,
// random backpressure against an arithmetic model, async reset and accumulator saturation.
module tb_approx_adder_error_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, in_valid, in_ready, busy, done;
    logic [15:0] num_samples, a, b, asum, samples_seen, err_count;
    logic        acout;
    logic [39:0] sum_ed;
    logic [16:0] max_ed;

    logic        start2, valid2, ready2, busy2, done2, c2;
    logic [15:0] n2, a2, b2, s2, seen2, err2;
    logic [16:0] sum2, max2;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    approx_adder_error_monitor dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
        .Approx_Sum(asum), .Approx_Cout(acout), .busy(busy), .done(done),
        .samples_seen(samples_seen), .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed)
    );

    approx_adder_error_monitor #(.ACC_W(17)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .num_samples(n2),
        .in_valid(valid2), .in_ready(ready2), .A(a2), .B(b2),
        .Approx_Sum(s2), .Approx_Cout(c2), .busy(busy2), .done(done2),
        .samples_seen(seen2), .err_count(err2), .sum_ed(sum2), .max_ed(max2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [16:0] ap);
        a = x;
        b = y;
        {acout, asum} = ap;
    endtask

    logic [16:0] exact, ap, ed, m_max;
    logic [63:0] m_sum;
    int m_err, accepts, cyc, extra;

    initial begin
        rst = 1'b1; start = 0; num_samples = '0; in_valid = 0; drive(16'h0, 16'h0, 17'h0);
        start2 = 0; n2 = '0; valid2 = 0; a2 = '0; b2 = '0; s2 = '0; c2 = 0;
        #12;
        check("reset_ready", in_ready, 0);
        check("reset_busy_done", {busy, done}, 0);
        check("reset_stats", {samples_seen, err_count, sum_ed, max_ed} == '0, 1);
        rst = 1'b0;
        tick;

        // Three samples: one exact, two with error
        num_samples = 16'd3; start = 1; tick; start = 0;
        check("run_ready", in_ready, 1);
        check("run_busy", busy, 1);
        in_valid = 1;
        drive(16'h0003, 16'h0001, 17'h00004); tick;
        drive(16'h00FF, 16'h0001, 17'h000F0); tick;
        drive(16'hFFFF, 16'h0001, 17'h00000); tick;
        in_valid = 0;
        check("ready_drop", in_ready, 0);
        check("latency_seen", samples_seen, 1);
        tick;
        check("drain_not_done", done, 0);
        check("drain_sum", sum_ed, 40'h10);
        tick;
        check("t2_done", done, 1);
        check("t2_busy", busy, 0);
        check("t2_seen", samples_seen, 3);
        check("t2_err", err_count, 2);
        check("t2_sum", sum_ed, 40'h10010);
        check("t2_max", max_ed, 17'h10000);

        // Start in DONE clears and begins a run; start in RUN is ignored
        num_samples = 16'd2; start = 1; tick;
        check("restart_cleared", {samples_seen, err_count, sum_ed, max_ed} == '0, 1);
        check("restart_busy", {busy, done}, 2'b10);
        num_samples = 16'd5;
        in_valid = 1;
        drive(16'h0005, 16'h0005, 17'h0000A); tick;
        start = 0;
        drive(16'h0010, 16'h0010, 17'h00021); tick;
        check("start_in_run_ignored", in_ready, 0);
        drive(16'h0001, 16'h0001, 17'h00100); tick; tick;
        in_valid = 0;
        check("t6_done", done, 1);
        check("t6_seen", samples_seen, 2);
        check("t6_err", err_count, 1);
        check("t6_sum", sum_ed, 40'h1);
        check("t6_max", max_ed, 17'h1);

        // Zero-sample run from DONE with nonzero stats
        num_samples = 16'd0; start = 1; in_valid = 1; tick; start = 0;
        check("zero_done", done, 1);
        check("zero_stats", {samples_seen, err_count, sum_ed, max_ed} == '0, 1);
        check("zero_busy_ready", {busy, in_ready}, 0);
        tick; tick;
        check("zero_ready_held", in_ready, 0);
        check("zero_seen_held", samples_seen, 0);
        in_valid = 0;

        // 100 samples with random gaps against the arithmetic model
        num_samples = 16'd100; start = 1; tick; start = 0;
        m_err = 0; m_sum = '0; m_max = '0; accepts = 0; cyc = 0;
        while (accepts < 100 && cyc < 2000) begin
            in_valid = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            exact = {1'b0, a} + {1'b0, b};
            ap = ($urandom_range(0, 2) == 0) ? exact : 17'($urandom);
            {acout, asum} = ap;
            if (in_valid && in_ready) begin
                ed = (exact >= ap) ? exact - ap : ap - exact;
                if (ed != 0) m_err++;
                m_sum += 64'(ed);
                if (ed > m_max) m_max = ed;
                accepts++;
            end
            tick;
            cyc++;
        end
        check("t4_accepts", accepts, 100);
        check("t4_ready_after_last", in_ready, 0);
        extra = 0;
        repeat (3) begin
            in_valid = 1;
            if (in_ready) extra++;
            tick;
        end
        in_valid = 0;
        check("t4_no_extra", extra, 0);
        check("t4_done", done, 1);
        check("t4_seen", samples_seen, 100);
        check("t4_err", err_count, 64'(m_err));
        check("t4_sum", sum_ed, m_sum);
        check("t4_max", max_ed, m_max);

        // Asynchronous reset in the middle of a run
        num_samples = 16'd10; start = 1; tick; start = 0;
        in_valid = 1;
        drive(16'h0000, 16'h0000, 17'h00005);
        repeat (4) tick;
        check("pre_reset_sum", sum_ed, 40'hA);
        #3 rst = 1'b1;
        #1;
        check("async_reset_stats", {samples_seen, err_count, sum_ed, max_ed} == '0, 1);
        check("async_reset_ctrl", {in_ready, busy, done}, 0);
        #2 rst = 1'b0;
        tick;
        check("post_reset_idle", {in_ready, busy, done}, 0);
        tick; tick;
        check("post_reset_flushed", samples_seen, 0);
        check("post_reset_sum", sum_ed, 0);
        in_valid = 0;

        // Saturating accumulator on the narrow instance
        n2 = 16'd3; start2 = 1; tick; start2 = 0;
        valid2 = 1; a2 = 16'h0; b2 = 16'h0; {c2, s2} = 17'h1FFFF;
        repeat (3) tick;
        valid2 = 0;
        check("sat_first", sum2, 17'h1FFFF);
        tick;
        check("sat_second", sum2, 17'h1FFFF);
        tick;
        check("sat_done", done2, 1);
        check("sat_final", sum2, 17'h1FFFF);
        check("sat_max", max2, 17'h1FFFF);
        check("sat_err", err2, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
